// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared types for the scoreboard hazard unit: forwarding select encoding and
// the scoreboard entry layout.
package scoreboard_hazard_unit_pkg;

  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  // Destination field is stored zero-extended, so NREG may be at most 256.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               v;
    logic [SB_RD_W-1:0] rd;
    logic               late;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage <-> hazard unit bundle. master = ID stage, slave = hazard unit.
// Handshake: ID offers an instruction with id_valid; it is consumed (issue=1)
// in a cycle with stall=0, otherwise ID must hold the same instruction.
interface scoreboard_hazard_unit_if #(
  parameter int AW = 5,
  parameter int FW = 2
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [AW-1:0] id_rd;
  logic          id_wr_en;
  logic          id_wr_late;
  logic          id_md;
  logic          id_hilo_rd;
  logic          branch_taken;
  logic          stall;
  logic          issue;
  logic          flush_if;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
  logic          md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_wr_en, id_wr_late, id_md, id_hilo_rd, branch_taken,
    input  stall, issue, flush_if, fwd_a, fwd_b, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_wr_en, id_wr_late, id_md, id_hilo_rd, branch_taken,
    output stall, issue, flush_if, fwd_a, fwd_b, md_busy
  );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_match.sv
// Youngest-match priority encoder over the scoreboard for one source operand.
module sb_match
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int PW    = 2
) (
  input  sb_entry_t [DEPTH-1:0] sb_i,
  input  logic [SB_RD_W-1:0]    src_i,
  input  logic                  used_i,
  output logic                  hit_o,
  output logic [PW-1:0]         pos_o,
  output logic                  late_o
);

  // Scan oldest to youngest so the lowest matching position is written last.
  always_comb begin
    hit_o  = 1'b0;
    pos_o  = '0;
    late_o = 1'b0;
    for (int p = DEPTH - 1; p >= 0; p--) begin
      if (used_i && (src_i != '0) && sb_i[p].v && (sb_i[p].rd == src_i)) begin
        hit_o  = 1'b1;
        pos_o  = PW'(p);
        late_o = sb_i[p].late;
      end
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Hazard, forwarding and stall controller: shift-register scoreboard of
// in-flight writes, load-use and HI/LO stalls, forward selects, IF flush gating.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int MDLAT      = 4
) (
  input logic                     Clk,
  input logic                     Rst,
  scoreboard_hazard_unit_if.slave hz
);

  localparam int AW = $clog2(NREG);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int MW = (MDLAT > 1) ? $clog2(MDLAT + 1) : 1;

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [FW-1:0]         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [MW-1:0]         mdc_q, mdc_d;

  logic          hit_a, hit_b, late_a, late_b;
  logic [FW-1:0] pos_a, pos_b;
  logic          luse, hilo_stall, stall, issue, md_busy;

  sb_match #(.DEPTH(DEPTH), .PW(FW)) u_match_a (
    .sb_i(sb_q), .src_i(SB_RD_W'(hz.id_rs)), .used_i(hz.id_rs_used),
    .hit_o(hit_a), .pos_o(pos_a), .late_o(late_a)
  );

  sb_match #(.DEPTH(DEPTH), .PW(FW)) u_match_b (
    .sb_i(sb_q), .src_i(SB_RD_W'(hz.id_rt)), .used_i(hz.id_rt_used),
    .hit_o(hit_b), .pos_o(pos_b), .late_o(late_b)
  );

  assign md_busy    = (mdc_q != '0);
  assign luse       = (hit_a && late_a && (pos_a < FW'(LOAD_STAGE))) ||
                      (hit_b && late_b && (pos_b < FW'(LOAD_STAGE)));
  assign hilo_stall = (hz.id_md || hz.id_hilo_rd) && md_busy;
  assign stall      = hz.id_valid && (luse || hilo_stall);
  assign issue      = hz.id_valid && !stall;

  always_comb begin
    sb_d       = '0;
    sb_d[0].v    = issue && hz.id_wr_en && (hz.id_rd != '0);
    sb_d[0].rd   = SB_RD_W'(hz.id_rd);
    sb_d[0].late = hz.id_wr_late;
    for (int p = 1; p < DEPTH; p++) begin
      sb_d[p] = sb_q[p-1];
    end

    // The entry in WB needs no forward: the register file writes before it reads.
    fwd_a_d = FW'(FWD_RF);
    fwd_b_d = FW'(FWD_RF);
    if (issue && hit_a && (pos_a < FW'(DEPTH - 1))) fwd_a_d = pos_a + FW'(FWD_EXMEM);
    if (issue && hit_b && (pos_b < FW'(DEPTH - 1))) fwd_b_d = pos_b + FW'(FWD_EXMEM);

    // The issue cycle is the first of the MDLAT cycles HI/LO is occupied.
    mdc_d = mdc_q;
    if (issue && hz.id_md) mdc_d = MW'(MDLAT - 1);
    else if (mdc_q != '0)  mdc_d = mdc_q - MW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sb_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      mdc_q   <= '0;
    end else begin
      sb_q    <= sb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      mdc_q   <= mdc_d;
    end
  end

  assign hz.stall    = stall;
  assign hz.issue    = issue;
  assign hz.flush_if = hz.id_valid && hz.branch_taken && !stall;
  assign hz.fwd_a    = fwd_a_q;
  assign hz.fwd_b    = fwd_b_q;
  assign hz.md_busy  = md_busy;

  logic unused_aw;
  assign unused_aw = ^{AW};

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit: default configuration plus a
// DEPTH=4 / LOAD_STAGE=2 instance driven with the same ID stream.
module tb_scoreboard_hazard_unit;
  import scoreboard_hazard_unit_pkg::*;

  logic Clk;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  scoreboard_hazard_unit_if #(.AW(5), .FW(2)) if0 ();
  scoreboard_hazard_unit_if #(.AW(5), .FW(3)) if1 ();

  scoreboard_hazard_unit #(.NREG(32), .DEPTH(3), .LOAD_STAGE(1), .MDLAT(4)) dut0 (
    .Clk(Clk), .Rst(Rst), .hz(if0)
  );
  scoreboard_hazard_unit #(.NREG(32), .DEPTH(4), .LOAD_STAGE(2), .MDLAT(4)) dut1 (
    .Clk(Clk), .Rst(Rst), .hz(if1)
  );

  // clock/reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // driver tasks
  task automatic drive(input logic v, input int rs, input logic rsu, input int rt,
                       input logic rtu, input int rd, input logic we, input logic late,
                       input logic md, input logic hilo, input logic br);
    if0.id_valid = v;   if1.id_valid = v;
    if0.id_rs = 5'(rs); if1.id_rs = 5'(rs);
    if0.id_rs_used = rsu; if1.id_rs_used = rsu;
    if0.id_rt = 5'(rt); if1.id_rt = 5'(rt);
    if0.id_rt_used = rtu; if1.id_rt_used = rtu;
    if0.id_rd = 5'(rd); if1.id_rd = 5'(rd);
    if0.id_wr_en = we;  if1.id_wr_en = we;
    if0.id_wr_late = late; if1.id_wr_late = late;
    if0.id_md = md;     if1.id_md = md;
    if0.id_hilo_rd = hilo; if1.id_hilo_rd = hilo;
    if0.branch_taken = br; if1.branch_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    repeat (2) @(posedge Clk);
    smp();
    chk("rst_stall", 32'(if0.stall), 0);
    chk("rst_issue", 32'(if0.issue), 0);
    chk("rst_fwd_a", 32'(if0.fwd_a), 0);
    chk("rst_fwd_b", 32'(if0.fwd_b), 0);
    chk("rst_md_busy", 32'(if0.md_busy), 0);
    chk("rst_flush", 32'(if0.flush_if), 0);
    step();
    Rst = 1'b0;

    // ALU -> ALU dependency
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    smp(); chk("alu_prod_issue", 32'(if0.issue), 1);
    step();
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0);
    smp(); chk("alu_dep_stall", 32'(if0.stall), 0);
    chk("alu_dep_issue", 32'(if0.issue), 1);
    step();
    idle();
    smp(); chk("alu_fwd_a", 32'(if0.fwd_a), 1);
    chk("alu_fwd_b", 32'(if0.fwd_b), 1);
    step();

    // load-use
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    smp(); chk("lw_issue", 32'(if0.issue), 1);
    step();
    drive(1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0);
    smp(); chk("lu_stall", 32'(if0.stall), 1);
    chk("lu_issue", 32'(if0.issue), 0);
    step();
    smp(); chk("lu_release_stall", 32'(if0.stall), 0);
    chk("lu_release_issue", 32'(if0.issue), 1);
    chk("lu_bubble_fwd_a", 32'(if0.fwd_a), 0);
    step();
    idle();
    smp(); chk("lu_fwd_a", 32'(if0.fwd_a), 2);
    chk("lu_fwd_b", 32'(if0.fwd_b), 0);
    step();

    // mult -> mfhi
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    smp(); chk("mult_issue", 32'(if0.issue), 1);
    chk("mult_busy_before", 32'(if0.md_busy), 0);
    step();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0);
    smp(); chk("mfhi_stall1", 32'(if0.stall), 1);
    chk("mfhi_busy1", 32'(if0.md_busy), 1);
    step();
    smp(); chk("mfhi_stall2", 32'(if0.stall), 1);
    step();
    smp(); chk("mfhi_stall3", 32'(if0.stall), 1);
    step();
    smp(); chk("mfhi_release_stall", 32'(if0.stall), 0);
    chk("mfhi_release_issue", 32'(if0.issue), 1);
    chk("mfhi_release_busy", 32'(if0.md_busy), 0);
    step();

    // register 0
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    smp(); chk("r0_write_issue", 32'(if0.issue), 1);
    step();
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0);
    smp(); chk("r0_read_stall", 32'(if0.stall), 0);
    chk("r0_read_issue", 32'(if0.issue), 1);
    step();
    idle();
    smp(); chk("r0_fwd_a", 32'(if0.fwd_a), 0);
    chk("r0_fwd_b", 32'(if0.fwd_b), 0);
    step();

    // taken branch during load-use stall
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    step();
    drive(1, 8, 1, 9, 1, 0, 0, 0, 0, 0, 1);
    smp(); chk("br_stall", 32'(if0.stall), 1);
    chk("br_flush_held", 32'(if0.flush_if), 0);
    step();
    smp(); chk("br_issue", 32'(if0.issue), 1);
    chk("br_flush", 32'(if0.flush_if), 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    smp(); chk("br_invalid_flush", 32'(if0.flush_if), 0);
    chk("br_invalid_stall", 32'(if0.stall), 0);
    chk("br_invalid_issue", 32'(if0.issue), 0);
    chk("br_fwd_a", 32'(if0.fwd_a), 2);
    step();

    // reset mid-operation
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 1, 1, 0, 0, 10, 1, 1, 0, 0, 0);
    step();
    drive(1, 10, 1, 0, 0, 11, 1, 0, 0, 0, 0);
    Rst = 1'b1;
    smp(); chk("prerst_stall", 32'(if0.stall), 1);
    chk("prerst_busy", 32'(if0.md_busy), 1);
    step();
    Rst = 1'b0;
    smp(); chk("postrst_stall", 32'(if0.stall), 0);
    chk("postrst_issue", 32'(if0.issue), 1);
    chk("postrst_busy", 32'(if0.md_busy), 0);
    chk("postrst_fwd_a", 32'(if0.fwd_a), 0);
    step();
    idle();
    smp(); chk("postrst_dep_fwd_a", 32'(if0.fwd_a), 0);
    step();

    // youngest match wins; match only in WB forwards from the register file
    drive(1, 1, 1, 0, 0, 12, 1, 0, 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 0, 14, 1, 0, 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 0, 12, 1, 0, 0, 0, 0);
    step();
    drive(1, 12, 1, 14, 1, 0, 0, 0, 0, 0, 0);
    smp(); chk("young_stall", 32'(if0.stall), 0);
    step();
    drive(1, 14, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    smp(); chk("young_fwd_a", 32'(if0.fwd_a), 1);
    chk("young_fwd_b", 32'(if0.fwd_b), 2);
    step();
    idle();
    smp(); chk("wb_only_fwd_a", 32'(if0.fwd_a), 0);
    chk("wb_only_fwd_b", 32'(if0.fwd_b), 2);
    step();

    // DEPTH=4, LOAD_STAGE=2: two-cycle load-use stall
    Rst = 1'b1;
    idle();
    step();
    Rst = 1'b0;
    smp(); chk("d4_rst_fwd_a", 32'(if1.fwd_a), 0);
    chk("d4_rst_stall", 32'(if1.stall), 0);
    step();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    smp(); chk("d4_lw_issue", 32'(if1.issue), 1);
    step();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    smp(); chk("d4_stall1", 32'(if1.stall), 1);
    step();
    smp(); chk("d4_stall2", 32'(if1.stall), 1);
    chk("d4_issue2", 32'(if1.issue), 0);
    step();
    smp(); chk("d4_release_stall", 32'(if1.stall), 0);
    chk("d4_release_issue", 32'(if1.issue), 1);
    step();
    idle();
    smp(); chk("d4_fwd_a", 32'(if1.fwd_a), 3);
    step();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
